sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Sits directly downstream of the MEM stage and replaces its on-chip data memory with the board's external 16-bit asynchronous SRAM.
- Accepts one 32-bit word read or write per request and splits it into two 16-bit SRAM half-word accesses (low half first).
- Holds ready low for the whole multi-cycle access; the top level drives a pipeline-wide freeze with ~ready.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 6: total cycles from the request cycle through the cycle where ready rises. Minimum 4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write request from MEM stage (level)
- rd_en  input  1  read request from MEM stage (level)
- address  input  32  byte address (ALU result)
- wdata  input  32  store data
- rdata  output  32  read data, registered
- ready  output  1  access complete / no access pending
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM half-word address
- SRAM_WE_N  output  1  write enable, active low
- SRAM_OE_N  output  1  output enable, active low
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0

Behaviour:

Address mapping:
- word = (address - BASE_ADDR) >> 2, truncated to 17 bits.
- Low half-word lives at SRAM_ADDR = {word,0}; high half-word at {word,1}.

States and transitions:
- IDLE
  - If wr_en or rd_en: capture address, wdata and op (write has priority if both are asserted), then go to LO.
  - Otherwise stay in IDLE.
- LO (1 cycle)
  - SRAM_ADDR = {word,0}.
  - Write: WE_N=0, DQ driven with wdata[15:0].
  - Read: OE_N=0; DQ sampled into lo_reg at the closing edge.
- HI (1 cycle)
  - SRAM_ADDR = {word,1}.
  - Write: WE_N=0, DQ driven with wdata[31:16].
  - Read: OE_N=0; DQ sampled; rdata <= {DQ, lo_reg} at the closing edge.
- WAIT
  - Counter holds here until cycle ACCESS_CYCLES-2 (counted from the request cycle = 0).
  - SRAM idle: WE_N=1, OE_N=1, DQ=Z.
  - With ACCESS_CYCLES=4 there are no WAIT cycles; go HI -> DONE.
- DONE (1 cycle)
  - ready=1, then go to IDLE.
  - A request still asserted in the following IDLE cycle counts as a new request.

ready (combinational):
- ready = (state==IDLE && !wr_en && !rd_en) || state==DONE.
- It is low in the request cycle itself.
- Default timing: ready is low for cycles 0..4 and high in cycle 5.

Bus and output rules:
- SRAM_DQ is high-Z in every state except write LO/HI; it is never driven during reads.
- SRAM_WE_N and SRAM_OE_N are never low simultaneously.
- SRAM_ADDR = 0 in IDLE.
- rdata holds its last read value across writes and idle periods; it changes only at the HI closing edge of a read.

Reset (synchronous; identical behaviour mid-access):
- state=IDLE, counter=0, rdata=0, lo_reg=0.
- SRAM_WE_N=1, SRAM_OE_N=1, DQ=Z.
- An aborted write may leave the low half written; no further SRAM cycles are issued.

Input stability:
- Changes to address, wdata, wr_en or rd_en after capture have no effect until DONE.

Test Plan:
- Write 0xDEADBEEF to address 1024 (wr_en held until ready):
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - WE_N low exactly in cycles 1-2.
  - ready low in cycles 0-4, high in cycle 5, then IDLE.
- Read address 1024 after the write:
  - OE_N low in cycles 1-2, DQ never driven by the DUT.
  - rdata=0xDEADBEEF when ready rises in cycle 5.
- Write 0x12345678 to address 1028, then read it back:
  - SRAM_ADDR 2 (0x5678) then 3 (0x1234).
  - Read returns 0x12345678.
  - Address 1024 still reads 0xDEADBEEF.
- wr_en=rd_en=1, address 1032, wdata 0xCAFEF00D:
  - Write performed, SRAM[4]=0xF00D, SRAM[5]=0xCAFE.
  - rdata unchanged.
  - No enables -> ready=1 continuously, WE_N=OE_N=1.
- Assert rst in the HI cycle of a write:
  - Next cycle state=IDLE, WE_N=1, DQ=Z, rdata=0.
  - SRAM[word*2+1] not written.
  - ready=1 once enables are deasserted.
- ACCESS_CYCLES=4, back-to-back reads with rd_en held high:
  - ready pulses high every 4th cycle (cycle 3, 7, ...).
  - Each pulse is followed by a fresh access.

Source files
------------

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Bridges the MEM-stage 32-bit load/store port onto a 16-bit
//               asynchronous SRAM. Each request becomes two half-word SRAM
//               cycles (low half first), padded with idle cycles so every
//               access takes exactly ACCESS_CYCLES cycles including the
//               request cycle. ready is low for the whole access so the top
//               level can freeze the pipeline with ~ready.
// Ports       :
//   clk, rst          - system clock, synchronous active-high reset
//   wr_en, rd_en      - level write / read request (write wins if both)
//   address, wdata    - byte address and store data, captured at request
//   rdata             - registered read data, updated only by reads
//   ready             - access complete, or idle with no request pending
//   SRAM_DQ           - bidirectional SRAM data bus
//   SRAM_ADDR         - SRAM half-word address
//   SRAM_WE_N/OE_N    - active-low write / output enables
//   SRAM_CE_N/UB_N/LB_N - tied low (chip and both byte lanes always enabled)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    // Counter must reach ACCESS_CYCLES-1 (the DONE cycle).
    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    // Last cycle index spent before DONE; HI (cycle 2) already meets it when
    // ACCESS_CYCLES is 4, which removes the WAIT state entirely.
    localparam logic [CW-1:0] c_WAIT_LAST = CW'(ACCESS_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_count;
    logic [16:0]    r_word;
    logic [31:0]    r_wdata;
    logic           r_is_write;
    logic [15:0]    r_lo;
    logic [31:0]    r_rdata;

    logic [31:0]    w_offset;
    logic [16:0]    w_word;
    logic           w_request;
    logic           w_drive;
    logic [15:0]    w_dq_out;
    logic           w_unused_bits;

    assign w_request = wr_en | rd_en;
    assign w_offset  = address - 32'(BASE_ADDR);
    assign w_word    = w_offset[18:2];
    // Byte offset and upper address bits fall outside the 17-bit word space.
    assign w_unused_bits = &{1'b0, w_offset[31:19], w_offset[1:0]};

    // ------------------------------------------------------------------------
    // State register, request capture, read-data assembly
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_lo       <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        r_word     <= w_word;
                        r_wdata    <= wdata;
                        r_is_write <= wr_en;
                        r_count    <= CW'(1);
                    end else begin
                        r_count    <= '0;
                    end
                end
                S_LO: begin
                    if (!r_is_write) begin
                        r_lo <= SRAM_DQ;
                    end
                    r_count <= r_count + 1'b1;
                end
                S_HI: begin
                    if (!r_is_write) begin
                        r_rdata <= {SRAM_DQ, r_lo};
                    end
                    r_count <= r_count + 1'b1;
                end
                S_WAIT: begin
                    r_count <= r_count + 1'b1;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next state and SRAM/handshake outputs
    // Write strobes, output enable and bus drive are additionally gated by
    // rst so a reset landing mid-access stops the SRAM cycle in that very
    // cycle instead of completing the half-word in flight.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        SRAM_ADDR    = '0;
        SRAM_WE_N    = 1'b1;
        SRAM_OE_N    = 1'b1;
        w_drive      = 1'b0;
        w_dq_out     = '0;

        case (r_state)
            S_IDLE: begin
                ready = !w_request;
                if (w_request) begin
                    w_next_state = S_LO;
                end
            end
            S_LO: begin
                w_next_state = S_HI;
                SRAM_ADDR    = {r_word, 1'b0};
                if (r_is_write) begin
                    SRAM_WE_N = rst;
                    w_drive   = !rst;
                    w_dq_out  = r_wdata[15:0];
                end else begin
                    SRAM_OE_N = rst;
                end
            end
            S_HI: begin
                w_next_state = (r_count >= c_WAIT_LAST) ? S_DONE : S_WAIT;
                SRAM_ADDR    = {r_word, 1'b1};
                if (r_is_write) begin
                    SRAM_WE_N = rst;
                    w_drive   = !rst;
                    w_dq_out  = r_wdata[31:16];
                end else begin
                    SRAM_OE_N = rst;
                end
            end
            S_WAIT: begin
                if (r_count >= c_WAIT_LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                ready        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign SRAM_DQ   = w_drive ? w_dq_out : 16'bz;
    assign rdata     = r_rdata;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller. A behavioural
//               16-bit asynchronous SRAM sits on each DUT's bus; a word-level
//               reference (half-word array plus last-read value) predicts
//               memory contents and rdata, and per-access timing is checked
//               as bit masks of the cycles where each strobe/ready is active.
//               A second instance with ACCESS_CYCLES=4 checks back-to-back
//               reads with rd_en held high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clear;

    // ---------------- instance A (ACCESS_CYCLES = 6) ----------------
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
    logic [15:0] mem [0:255];

    // ---------------- instance B (ACCESS_CYCLES = 4) ----------------
    logic        wr_en_b, rd_en_b;
    logic [31:0] address_b, wdata_b;
    logic [31:0] rdata_b;
    logic        ready_b;
    wire  [15:0] sram_dq_b;
    logic [17:0] sram_addr_b;
    logic        sram_we_n_b, sram_oe_n_b, sram_ce_n_b, sram_ub_n_b, sram_lb_n_b;
    logic [15:0] mem_b [0:255];

    // ---------------- reference model ----------------
    logic [15:0] ref_half [0:255];
    logic [31:0] ref_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(6)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
    );

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b),
        .address(address_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b),
        .SRAM_DQ(sram_dq_b), .SRAM_ADDR(sram_addr_b),
        .SRAM_WE_N(sram_we_n_b), .SRAM_OE_N(sram_oe_n_b),
        .SRAM_CE_N(sram_ce_n_b), .SRAM_UB_N(sram_ub_n_b), .SRAM_LB_N(sram_lb_n_b)
    );

    // Behavioural asynchronous SRAMs: drive on OE_N low (write not active),
    // capture the bus at the end of every cycle with WE_N low.
    assign sram_dq   = (!sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'bz;
    assign sram_dq_b = (!sram_oe_n_b && sram_we_n_b) ? mem_b[sram_addr_b[7:0]] : 16'bz;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]   <= 16'h0000;
                mem_b[i] <= 16'h0000;
            end
            mem_b[6] <= 16'hBEEF;
            mem_b[7] <= 16'h0123;
        end else begin
            if (!sram_we_n && !sram_ce_n)
                mem[sram_addr[7:0]] <= sram_dq;
            if (!sram_we_n_b && !sram_ce_n_b)
                mem_b[sram_addr_b[7:0]] <= sram_dq_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access on instance A. Enables are held until ready; the
    // address/data inputs are scrambled after the request cycle to show that
    // only the captured values matter.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [15:0] we_mask, oe_mask;
        logic [17:0] addr1, addr2;
        logic        both_low;
        logic        is_wr;
        int          rdy_cyc;
        int          word;

        is_wr    = w;
        word     = int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
        we_mask  = '0;
        oe_mask  = '0;
        addr1    = '0;
        addr2    = '0;
        both_low = 1'b0;
        rdy_cyc  = -1;

        if (is_wr) begin
            ref_half[2*word]     = d[15:0];
            ref_half[2*word + 1] = d[31:16];
        end else begin
            ref_rdata = {ref_half[2*word + 1], ref_half[2*word]};
        end

        wr_en = w; rd_en = r; address = a; wdata = d;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            we_mask[c] = !sram_we_n;
            oe_mask[c] = !sram_oe_n;
            if (!sram_we_n && !sram_oe_n) both_low = 1'b1;
            if (c == 1) addr1 = sram_addr;
            if (c == 2) addr2 = sram_addr;
            if (ready) begin
                rdy_cyc = c;
                break;
            end
            @(posedge clk); #1;
            address = $urandom;
            wdata   = $urandom;
        end

        check("ready_cycle",  32'(rdy_cyc), 32'd5);
        check("we_n_cycles",  32'(we_mask), is_wr ? 32'h6 : 32'h0);
        check("oe_n_cycles",  32'(oe_mask), is_wr ? 32'h0 : 32'h6);
        check("addr_lo",      32'(addr1), 32'(2*word));
        check("addr_hi",      32'(addr2), 32'(2*word + 1));
        check("we_oe_overlap", 32'(both_low), 32'd0);
        check("rdata",        rdata, ref_rdata);
        if (is_wr) begin
            check("sram_lo", 32'(mem[2*word]),     32'(ref_half[2*word]));
            check("sram_hi", 32'(mem[2*word + 1]), 32'(ref_half[2*word + 1]));
        end

        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mask_r, mask_w, mask_o;
        int          w, op;
        logic [31:0] d;

        rst = 1'b1; mem_clear = 1'b1;
        wr_en = 0; rd_en = 0; address = 0; wdata = 0;
        wr_en_b = 0; rd_en_b = 0; address_b = 32'd1036; wdata_b = 0;
        for (int i = 0; i < 256; i++) ref_half[i] = 16'h0000;
        ref_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mem_clear = 1'b0;

        // Reset / idle state
        @(negedge clk);
        check("rst_ready",  32'(ready), 32'd1);
        check("rst_we_n",   32'(sram_we_n), 32'd1);
        check("rst_oe_n",   32'(sram_oe_n), 32'd1);
        check("rst_addr",   32'(sram_addr), 32'd0);
        check("rst_rdata",  rdata, 32'd0);
        check("tied_lows",  32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
        @(posedge clk); #1;

        // Directed sequence
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        access(1'b1, 1'b0, 32'd1028, 32'h12345678);
        access(1'b0, 1'b1, 32'd1028, 32'h0);
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
        check("both_en_sram4", 32'(mem[4]), 32'h0000F00D);
        check("both_en_sram5", 32'(mem[5]), 32'h0000CAFE);

        // No enables: ready stays high, SRAM idle
        mask_r = '0; mask_w = '0; mask_o = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            mask_r[c] = ready; mask_w[c] = sram_we_n; mask_o[c] = sram_oe_n;
            @(posedge clk); #1;
        end
        check("idle_ready", 32'(mask_r), 32'h00FF);
        check("idle_we_n",  32'(mask_w), 32'h00FF);
        check("idle_oe_n",  32'(mask_o), 32'h00FF);

        // Reset during the HI cycle of a write to word 8
        access(1'b1, 1'b0, 32'd1056, 32'h11112222);
        wr_en = 1'b1; address = 32'd1056; wdata = 32'h33334444;   // cycle 0
        @(posedge clk); #1;                                        // cycle 1 (LO)
        @(posedge clk); #1;                                        // cycle 2 (HI)
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        ref_rdata = 32'h0;
        check("abort_we_n",  32'(sram_we_n), 32'd1);
        check("abort_oe_n",  32'(sram_oe_n), 32'd1);
        check("abort_rdata", rdata, 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_addr",  32'(sram_addr), 32'd0);
        check("abort_hi_untouched", 32'(mem[17]), 32'h00001111);
        @(posedge clk); #1;

        // Randomized traffic (word 8 excluded: its low half is indeterminate)
        for (int n = 0; n < 24; n++) begin
            w  = int'($urandom_range(0, 31));
            if (w == 8) w = 9;
            op = int'($urandom_range(0, 2));
            d  = $urandom;
            access(op != 1, op != 0, 32'd1024 + 32'(4*w), d);
        end

        // Instance B: back-to-back reads with rd_en held high
        mask_r = '0; mask_o = '0; mask_w = '0;
        rd_en_b = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            mask_r[c] = ready_b; mask_o[c] = !sram_oe_n_b; mask_w[c] = !sram_we_n_b;
            @(posedge clk); #1;
        end
        rd_en_b = 1'b0;
        check("b2b_ready", 32'(mask_r), 32'h8888);
        check("b2b_oe_n",  32'(mask_o), 32'h6666);
        check("b2b_we_n",  32'(mask_w), 32'h0000);
        check("b2b_rdata", rdata_b, 32'h0123BEEF);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
